// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage between the PC register and the IF/ID register.
// Accepts a fetch address, issues a single-outstanding read to instruction
// memory, and returns the instruction with its PC to decode. Requests a PC
// stall while busy, discards wrong-path data on a redirect, and parks one
// memory response in a skid buffer while decode is stalled, because memory
// responses cannot be back-pressured.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous reset, active low
//   pc_i          fetch address from the PC register
//   pc_valid_i    pc_i holds a new address to fetch
//   redirect_i    branch taken; flush in-flight and buffered fetches
//   stall_i       decode stalled; hold inst_* outputs
//   mem_req_o     read request to instruction memory
//   mem_addr_o    read address (meaningful while mem_req_o=1)
//   mem_gnt_i     request accepted this cycle
//   mem_rvalid_i  read data valid (one per grant, earliest cycle after gnt)
//   mem_rdata_i   read data
//   inst_o        fetched instruction
//   inst_pc_o     PC of inst_o
//   inst_valid_o  inst_o / inst_pc_o valid
//   stall_req_o   PC must hold; fetch unit busy
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    input  logic              redirect_i,
    input  logic              stall_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stall_req_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [ADDR_W-1:0]   skid_pc_r;
    logic [DATA_W-1:0]   inst_r;
    logic [ADDR_W-1:0]   inst_pc_r;
    logic                inst_valid_r;
    logic                mem_req_r;
    logic                stall_req_r;

    logic                accept_s;      // capture pc_i into addr_r
    logic                load_mem_s;    // memory data straight to output register
    logic                fill_skid_s;   // memory data parked in skid buffer
    logic                load_skid_s;   // skid buffer moves to output register
    logic                clear_skid_s;  // skid buffer emptied

    // Next-state and datapath control decode
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        load_mem_s   = 1'b0;
        fill_skid_s  = 1'b0;
        load_skid_s  = 1'b0;
        clear_skid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A redirect in the same cycle makes pc_i a wrong-path address.
                if (redirect_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (pc_valid_i) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A grant on the redirect cycle still owes us one response.
                if (redirect_i) begin
                    state_nxt_s = mem_gnt_i ? ST_DROP : ST_IDLE;
                end else if (mem_gnt_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    state_nxt_s = mem_rvalid_i ? ST_IDLE : ST_DROP;
                end else if (mem_rvalid_i) begin
                    // Output register is free if empty or consumed this cycle.
                    if (!inst_valid_r || !stall_i) begin
                        load_mem_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        fill_skid_s = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    clear_skid_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else if (!stall_i) begin
                    load_skid_s  = 1'b1;
                    clear_skid_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                // The single outstanding response ends the drop whether or not
                // another redirect arrives with it; a redirect alone stays here.
                if (mem_rvalid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered request/stall flags decoded from next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            stall_req_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_req_r   <= (state_nxt_s == ST_REQ);
            stall_req_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Fetch address register, held stable for the whole request
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            addr_r <= pc_i;
        end else begin
            addr_r <= addr_r;
        end
    end

    // One-entry skid buffer for responses arriving while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            skid_data_r <= {DATA_W{1'b0}};
            skid_pc_r   <= {ADDR_W{1'b0}};
        end else if (fill_skid_s) begin
            skid_data_r <= mem_rdata_i;
            skid_pc_r   <= addr_r;
        end else if (clear_skid_s) begin
            skid_data_r <= {DATA_W{1'b0}};
            skid_pc_r   <= {ADDR_W{1'b0}};
        end else begin
            skid_data_r <= skid_data_r;
            skid_pc_r   <= skid_pc_r;
        end
    end

    // Output register toward decode
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_r       <= {DATA_W{1'b0}};
            inst_pc_r    <= {ADDR_W{1'b0}};
            inst_valid_r <= 1'b0;
        end else if (redirect_i) begin
            inst_valid_r <= 1'b0;
        end else if (load_mem_s) begin
            inst_r       <= mem_rdata_i;
            inst_pc_r    <= addr_r;
            inst_valid_r <= 1'b1;
        end else if (load_skid_s) begin
            inst_r       <= skid_data_r;
            inst_pc_r    <= skid_pc_r;
            inst_valid_r <= 1'b1;
        end else if (!stall_i) begin
            // Decode consumed the instruction and nothing new replaces it.
            inst_valid_r <= 1'b0;
        end else begin
            inst_valid_r <= inst_valid_r;
        end
    end

    assign mem_req_o    = mem_req_r;
    assign mem_addr_o   = addr_r;
    assign stall_req_o  = stall_req_r;
    assign inst_o       = inst_r;
    assign inst_pc_o    = inst_pc_r;
    assign inst_valid_o = inst_valid_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vectors, a transaction-level
// reference model compared on every cycle, plus literal spot checks.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        redirect_i;
    logic        stall_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stall_req_o;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .redirect_i   (redirect_i),
        .stall_i      (stall_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .stall_req_o  (stall_req_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_req;      // request presented, not yet granted
    bit          m_wait;     // granted, response still owed
    bit          m_keep;     // owed response is on the correct path
    logic [31:0] m_addr;
    logic [63:0] m_skid[$];  // {data, pc}
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;

    task automatic model_step();
        bit          took;
        logic [63:0] e;
        took = 1'b0;
        if (!rst) begin
            m_req = 1'b0; m_wait = 1'b0; m_keep = 1'b0; m_addr = 32'h0;
            m_skid.delete();
            m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'h0;
        end else if (redirect_i) begin
            m_valid = 1'b0;
            m_skid.delete();
            if (m_req) begin
                m_req = 1'b0;
                if (mem_gnt_i) begin m_wait = 1'b1; m_keep = 1'b0; end
            end else if (m_wait) begin
                if (mem_rvalid_i) m_wait = 1'b0;
                else m_keep = 1'b0;
            end
        end else begin
            if (m_skid.size() != 0) begin
                if (!stall_i) begin
                    e = m_skid.pop_front();
                    m_inst = e[63:32]; m_pc = e[31:0]; m_valid = 1'b1; took = 1'b1;
                end
            end else if (m_req) begin
                if (mem_gnt_i) begin m_req = 1'b0; m_wait = 1'b1; m_keep = 1'b1; end
            end else if (m_wait) begin
                if (mem_rvalid_i) begin
                    m_wait = 1'b0;
                    if (m_keep) begin
                        if (!m_valid || !stall_i) begin
                            m_inst = mem_rdata_i; m_pc = m_addr; m_valid = 1'b1; took = 1'b1;
                        end else begin
                            m_skid.push_back({mem_rdata_i, m_addr});
                        end
                    end
                end
            end else if (pc_valid_i) begin
                m_req = 1'b1; m_addr = pc_i;
            end
            if (!took && !stall_i) m_valid = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: DUT outputs against the model on every falling edge
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("mem_req", {63'h0, mem_req_o}, {63'h0, m_req});
            chk("mem_addr", {32'h0, mem_addr_o}, {32'h0, m_addr});
            chk("stall_req", {63'h0, stall_req_o},
                {63'h0, (m_req || m_wait || (m_skid.size() != 0))});
            chk("inst_valid", {63'h0, inst_valid_o}, {63'h0, m_valid});
            if (m_valid) begin
                chk("inst", {32'h0, inst_o}, {32'h0, m_inst});
                chk("inst_pc", {32'h0, inst_pc_o}, {32'h0, m_pc});
            end
        end
    end

    // One cycle of stimulus; returns at the falling edge after the clock edge
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic rd,
                       input logic st, input logic g, input logic rv,
                       input logic [31:0] dat);
        pc_valid_i   = pv;
        pc_i         = pc;
        redirect_i   = rd;
        stall_i      = st;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = dat;
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        cyc(1'b0, 32'h0, 1'b0, st, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        pc_valid_i = 1'b0; pc_i = 32'h0; redirect_i = 1'b0; stall_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        idle(1'b0);
        idle(1'b0);
        chk("rst_mem_req", {63'h0, mem_req_o}, 64'h0);
        chk("rst_stall_req", {63'h0, stall_req_o}, 64'h0);
        chk("rst_inst_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("rst_inst", {32'h0, inst_o}, 64'h0);
        check_en = 1'b1;
        rst = 1'b1;
        idle(1'b0);

        // Basic fetch
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("basic_c1_req", {63'h0, mem_req_o}, 64'h1);
        chk("basic_c1_stall", {63'h0, stall_req_o}, 64'h1);
        chk("basic_c1_addr", {32'h0, mem_addr_o}, 64'h100);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("basic_c2_stall", {63'h0, stall_req_o}, 64'h1);
        chk("basic_c2_req", {63'h0, mem_req_o}, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500093);
        chk("basic_c3_valid", {63'h0, inst_valid_o}, 64'h1);
        chk("basic_c3_inst", {32'h0, inst_o}, 64'h00500093);
        chk("basic_c3_pc", {32'h0, inst_pc_o}, 64'h100);
        chk("basic_c3_stall", {63'h0, stall_req_o}, 64'h0);
        idle(1'b0);
        chk("basic_c4_valid", {63'h0, inst_valid_o}, 64'h0);

        // Grant withheld three cycles
        cyc(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("gdly_req", {63'h0, mem_req_o}, 64'h1);
            chk("gdly_addr", {32'h0, mem_addr_o}, 64'h104);
            idle(1'b0);
        end
        chk("gdly_c4_req", {63'h0, mem_req_o}, 64'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("gdly_c5_valid", {63'h0, inst_valid_o}, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00113);
        chk("gdly_c6_valid", {63'h0, inst_valid_o}, 64'h1);
        chk("gdly_c6_pc", {32'h0, inst_pc_o}, 64'h104);
        idle(1'b0);

        // Redirect while waiting for data
        cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rdw_stall", {63'h0, stall_req_o}, 64'h1);
        idle(1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("rdw_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("rdw_stall_off", {63'h0, stall_req_o}, 64'h0);
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678);
        chk("rdw_next_inst", {32'h0, inst_o}, 64'h12345678);
        chk("rdw_next_pc", {32'h0, inst_pc_o}, 64'h300);
        idle(1'b0);

        // Redirect coincident with grant
        cyc(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rdg_stall", {63'h0, stall_req_o}, 64'h1);
        chk("rdg_req", {63'h0, mem_req_o}, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        chk("rdg_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("rdg_stall_off", {63'h0, stall_req_o}, 64'h0);

        // pc_valid with redirect ignored; redirect in REQ withdraws request
        cyc(1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("idle_rd_req", {63'h0, mem_req_o}, 64'h0);
        cyc(1'b1, 32'h704, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("req_rd_req", {63'h0, mem_req_o}, 64'h0);
        chk("req_rd_stall", {63'h0, stall_req_o}, 64'h0);

        // Skid buffer
        cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        chk("skid_a", {32'h0, inst_o}, 64'h11);
        cyc(1'b1, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22);
        chk("skid_hold_stall", {63'h0, stall_req_o}, 64'h1);
        chk("skid_hold_inst", {32'h0, inst_o}, 64'h11);
        chk("skid_hold_pc", {32'h0, inst_pc_o}, 64'h400);
        idle(1'b1);
        chk("skid_hold2_inst", {32'h0, inst_o}, 64'h11);
        idle(1'b0);
        chk("skid_rel_inst", {32'h0, inst_o}, 64'h22);
        chk("skid_rel_pc", {32'h0, inst_pc_o}, 64'h404);
        chk("skid_rel_valid", {63'h0, inst_valid_o}, 64'h1);
        chk("skid_rel_stall", {63'h0, stall_req_o}, 64'h0);
        idle(1'b0);

        // Redirect while holding the skid entry
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h440, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33);
        cyc(1'b1, 32'h444, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("hold_rd_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("hold_rd_stall", {63'h0, stall_req_o}, 64'h0);
        idle(1'b0);
        chk("hold_rd_after", {63'h0, inst_valid_o}, 64'h0);

        // Reset mid-WAIT, then a stray response
        cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        idle(1'b0);
        chk("rw_mem_req", {63'h0, mem_req_o}, 64'h0);
        chk("rw_addr", {32'h0, mem_addr_o}, 64'h0);
        chk("rw_inst", {32'h0, inst_o}, 64'h0);
        chk("rw_pc", {32'h0, inst_pc_o}, 64'h0);
        chk("rw_stall", {63'h0, stall_req_o}, 64'h0);
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
        chk("rw_stray_valid", {63'h0, inst_valid_o}, 64'h0);
        idle(1'b0);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
